i2c_target_rw: RTL

Parametrised I2C target (slave) that supports both write and read transactions to an 8-bit register space. It has a configurable address, an auto-incrementing register pointer, repeated-START write-then-read, and optional clock stretching. It sits between the I2C pads and the register-file/SPI bridge backend, exposing simple write-strobe and read-request ports.

---
 rtl/i2c_target_rw.sv | 299 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_target_rw.sv
// I2C target with an 8-bit auto-incrementing register pointer, write strobes and read requests.
// Optional read clock stretching on rd_valid is enabled by defining I2C_STRETCH_EN.
module i2c_target_rw #(
   parameter logic [6:0] I2C_ADDR    = 7'h28,
   parameter int         SYNC_STAGES = 3,
   parameter int         AUTO_INC    = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       scl_oe,
   output logic       sda_oe,
   output logic       wr_en,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       rd_en,
   output logic [7:0] rd_addr,
   input  logic [7:0] rd_data,
   input  logic       rd_valid,
   output logic       bus_active,
   output logic       addressed
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_ADDR,
      S_A_ACK,
      S_WR_DATA,
      S_W_ACK,
      S_RD_LOAD,
      S_RD_DATA,
      S_M_ACK,
      S_IGNORE
   } state_t;

   state_t state, state_d;

   logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
   logic scl_cur, scl_old, sda_cur, sda_old;
   logic scl_rise, scl_fall, start_det, stop_det;

   logic [7:0] shreg, shreg_d;
   logic [7:0] ptr, ptr_d, ptr_inc;
   logic [7:0] new_byte;
   logic [2:0] bit_cnt, bit_cnt_d;
   logic [1:0] ld_cnt, ld_cnt_d;
   logic       first_byte, first_d;
   logic       rw, rw_d;
   logic       phase, phase_d;
   logic       sda_oe_d, wr_en_d, rd_en_d, bus_active_d, addressed_d;
   logic [7:0] wr_addr_d, wr_data_d, rd_addr_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync <= '1;
         sda_sync <= '1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      end
   end

   // Edges are judged on the two oldest stages so SCL and SDA stay aligned.
   assign scl_cur   = scl_sync[SYNC_STAGES-2];
   assign scl_old   = scl_sync[SYNC_STAGES-1];
   assign sda_cur   = sda_sync[SYNC_STAGES-2];
   assign sda_old   = sda_sync[SYNC_STAGES-1];
   assign scl_rise  = scl_cur & ~scl_old;
   assign scl_fall  = ~scl_cur & scl_old;
   assign start_det = scl_cur & scl_old & sda_old & ~sda_cur;
   assign stop_det  = scl_cur & scl_old & ~sda_old & sda_cur;

   assign new_byte = {shreg[6:0], sda_cur};
   assign ptr_inc  = (AUTO_INC != 0) ? ptr + 8'd1 : ptr;

`ifdef I2C_STRETCH_EN
   logic scl_oe_q, scl_oe_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) scl_oe_q <= 1'b0;
      else        scl_oe_q <= scl_oe_d;
   end

   assign scl_oe = scl_oe_q;
`else
   logic unused_stretch;

   assign unused_stretch = rd_valid;
   assign scl_oe         = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         shreg      <= '0;
         ptr        <= '0;
         bit_cnt    <= '0;
         ld_cnt     <= '0;
         first_byte <= 1'b0;
         rw         <= 1'b0;
         phase      <= 1'b0;
         sda_oe     <= 1'b0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         rd_en      <= 1'b0;
         rd_addr    <= '0;
         bus_active <= 1'b0;
         addressed  <= 1'b0;
      end else begin
         state      <= state_d;
         shreg      <= shreg_d;
         ptr        <= ptr_d;
         bit_cnt    <= bit_cnt_d;
         ld_cnt     <= ld_cnt_d;
         first_byte <= first_d;
         rw         <= rw_d;
         phase      <= phase_d;
         sda_oe     <= sda_oe_d;
         wr_en      <= wr_en_d;
         wr_addr    <= wr_addr_d;
         wr_data    <= wr_data_d;
         rd_en      <= rd_en_d;
         rd_addr    <= rd_addr_d;
         bus_active <= bus_active_d;
         addressed  <= addressed_d;
      end
   end

   always_comb begin
      state_d      = state;
      shreg_d      = shreg;
      ptr_d        = ptr;
      bit_cnt_d    = bit_cnt;
      ld_cnt_d     = ld_cnt;
      first_d      = first_byte;
      rw_d         = rw;
      phase_d      = phase;
      sda_oe_d     = sda_oe;
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr;
      wr_data_d    = wr_data;
      rd_en_d      = 1'b0;
      rd_addr_d    = rd_addr;
      bus_active_d = bus_active;
      addressed_d  = addressed;
`ifdef I2C_STRETCH_EN
      scl_oe_d     = scl_oe_q;
`endif

      if (stop_det) begin
         state_d      = S_IDLE;
         sda_oe_d     = 1'b0;
         bus_active_d = 1'b0;
         addressed_d  = 1'b0;
`ifdef I2C_STRETCH_EN
         scl_oe_d     = 1'b0;
`endif
      end else if (start_det) begin
         state_d      = S_ADDR;
         bit_cnt_d    = 3'd0;
         sda_oe_d     = 1'b0;
         bus_active_d = 1'b1;
         addressed_d  = 1'b0;
`ifdef I2C_STRETCH_EN
         scl_oe_d     = 1'b0;
`endif
      end else begin
         case (state)
            S_ADDR: begin
               if (scl_rise) begin
                  shreg_d   = new_byte;
                  bit_cnt_d = bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     bit_cnt_d = 3'd0;
                     phase_d   = 1'b0;
                     if (new_byte[7:1] == I2C_ADDR) begin
                        rw_d    = new_byte[0];
                        first_d = ~new_byte[0];
                        state_d = S_A_ACK;
                     end else begin
                        state_d = S_IGNORE;
                     end
                  end
               end
            end

            // ACK spans two SCL falls: drive on the first, release on the second.
            S_A_ACK, S_W_ACK: begin
               if (scl_fall) begin
                  if (!phase) begin
                     sda_oe_d = 1'b1;
                     phase_d  = 1'b1;
                     if (state == S_A_ACK) addressed_d = 1'b1;
                  end else begin
                     sda_oe_d  = 1'b0;
                     phase_d   = 1'b0;
                     bit_cnt_d = 3'd0;
                     ld_cnt_d  = 2'd0;
                     state_d   = (state == S_A_ACK && rw) ? S_RD_LOAD : S_WR_DATA;
                  end
               end
            end

            S_WR_DATA: begin
               if (scl_rise) begin
                  shreg_d   = new_byte;
                  bit_cnt_d = bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     bit_cnt_d = 3'd0;
                     phase_d   = 1'b0;
                     state_d   = S_W_ACK;
                     if (first_byte) begin
                        ptr_d   = new_byte;
                        first_d = 1'b0;
                     end else begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = ptr;
                        wr_data_d = new_byte;
                        ptr_d     = ptr_inc;
                     end
                  end
               end
            end

            S_RD_LOAD: begin
               case (ld_cnt)
                  2'd0: begin
                     rd_en_d   = 1'b1;
                     rd_addr_d = ptr;
                     ld_cnt_d  = 2'd1;
                  end
                  2'd1: begin
                     ld_cnt_d = 2'd2;
`ifdef I2C_STRETCH_EN
                     scl_oe_d = 1'b1;
`endif
                  end
                  2'd2: begin
`ifdef I2C_STRETCH_EN
                     if (rd_valid) begin
                        shreg_d  = rd_data;
                        sda_oe_d = ~rd_data[7];
                        ld_cnt_d = 2'd3;
                     end
`else
                     shreg_d   = rd_data;
                     sda_oe_d  = ~rd_data[7];
                     bit_cnt_d = 3'd0;
                     state_d   = S_RD_DATA;
`endif
                  end
                  default: begin
`ifdef I2C_STRETCH_EN
                     scl_oe_d  = 1'b0;
`endif
                     bit_cnt_d = 3'd0;
                     state_d   = S_RD_DATA;
                  end
               endcase
            end

            // Rotating keeps bit 7 the one on the wire.
            S_RD_DATA: begin
               if (scl_fall) begin
                  if (bit_cnt == 3'd7) begin
                     sda_oe_d = 1'b0;
                     ptr_d    = ptr_inc;
                     phase_d  = 1'b0;
                     state_d  = S_M_ACK;
                  end else begin
                     shreg_d   = {shreg[6:0], shreg[7]};
                     sda_oe_d  = ~shreg[6];
                     bit_cnt_d = bit_cnt + 3'd1;
                  end
               end
            end

            // The ACK is sampled on the rise; the next byte loads only once SCL is low again.
            S_M_ACK: begin
               if (!phase) begin
                  if (scl_rise) begin
                     if (sda_cur) state_d = S_IGNORE;
                     else         phase_d = 1'b1;
                  end
               end else if (scl_fall) begin
                  phase_d  = 1'b0;
                  ld_cnt_d = 2'd0;
                  state_d  = S_RD_LOAD;
               end
            end

            default: ;
         endcase
      end
   end

endmodule
